// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// Master is the controller. Slave is the datapath side, which supplies op, zf and mem_ready.
interface multicycle_control_if;
  logic [5:0] op;
  logic       zf;
  logic       mem_ready;
  logic       pc_en;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  op, zf, mem_ready,
    output pc_en, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op
  );

  modport slave (
    output op, zf, mem_ready,
    input  pc_en, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM (lw, sw, R-type, beq, j, addi) with Moore outputs decoded from state.
// Optional macro MC_MEM_WAIT_EN stalls FETCH, MEMRD and MEMWR until mem_ready is high.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q, state_d;
  logic   mem_ok;
  logic   pc_write;
  logic   pc_write_cond;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 3'b000;
    bus.pc_source  = 2'b00;
    bus.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        // IR load and PC increment wait for mem_ready so the PC advances once per fetch
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = mem_ok;
        pc_write      = mem_ok;
        state_d       = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RT:        state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d        = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.op == OP_LW)      state_d = MEMRD;
        else if (bus.op == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_d      = mem_ok ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        state_d       = mem_ok ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
        state_d       = ALUWB;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b001;
        bus.pc_source = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_source = 2'b10;
        pc_write      = 1'b1;
        state_d       = FETCH;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
    bus.pc_en = pc_write | (pc_write_cond & bus.zf);
    // Reset silences every control immediately, abandoning the instruction mid-flight
    if (reset) begin
      bus.pc_en      = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 3'b000;
      bus.pc_source  = 2'b00;
      bus.illegal_op = 1'b0;
    end
  end

  assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expectations, negedge monitor checks.
// Expected control words are hand-derived per state; MC_MEM_WAIT_EN adds the wait-state vectors.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  // {pc_en,i_or_d,ir_write,mem_read,mem_write,mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source,illegal_op}
  localparam logic [16:0] C_ZERO  = 17'b0_0_0_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_FETCH = 17'b1_0_1_1_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_FWAIT = 17'b0_0_0_1_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_000_00_0;
  localparam logic [16:0] C_ILL   = 17'b0_0_0_0_0_0_0_0_0_11_000_00_1;
  localparam logic [16:0] C_MADR  = 17'b0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [16:0] C_MRD   = 17'b0_1_0_1_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_1_0_1_0_00_000_00_0;
  localparam logic [16:0] C_MWR   = 17'b0_1_0_0_1_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_EXEC  = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [16:0] C_AWB   = 17'b0_0_0_0_0_0_1_1_0_00_000_00_0;
  localparam logic [16:0] C_BR1   = 17'b1_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [16:0] C_BR0   = 17'b0_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_00_000_10_0;
  localparam logic [16:0] C_IWB   = 17'b0_0_0_0_0_0_0_1_0_00_000_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

`ifdef MC_MEM_WAIT_EN
  localparam logic MR_LOW = 1'b1;
`else
  localparam logic MR_LOW = 1'b0;
`endif

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    int unsigned idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned nstep = 0;

  task automatic step(input logic rst, input logic [5:0] op, input logic zf, input logic mr,
                      input logic [3:0] st, input logic [16:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    bus.op = op;
    bus.zf = zf;
    bus.mem_ready = mr;
    e.st = st;
    e.ctl = ctl;
    e.idx = nstep;
    nstep++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {bus.pc_en, bus.i_or_d, bus.ir_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
             bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
             bus.pc_source, bus.illegal_op};
      checks++;
      if (bus.state !== e.st) begin
        failures++;
        $display("FAIL state step %0d: got %0d want %0d", e.idx, bus.state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctrl step %0d (state %0d): got %b want %b", e.idx, e.st, act, e.ctl);
      end
    end
  end

  initial begin
    bus.op = RT;
    bus.zf = 1'b0;
    bus.mem_ready = 1'b1;
    // reset held three cycles: everything quiet, state forced to FETCH
    repeat (3) step(1'b1, LW, 1'b0, 1'b1, 4'd0, C_ZERO);
    // lw then sw
    step(1'b0, LW, 1'b0, 1'b1, 4'd0, C_FETCH);
    step(1'b0, LW, 1'b0, 1'b1, 4'd1, C_DEC);
    step(1'b0, LW, 1'b0, 1'b1, 4'd2, C_MADR);
    step(1'b0, LW, 1'b0, 1'b1, 4'd3, C_MRD);
    step(1'b0, LW, 1'b0, 1'b1, 4'd4, C_MWB);
    step(1'b0, SW, 1'b0, MR_LOW, 4'd0, C_FETCH);
    step(1'b0, SW, 1'b0, MR_LOW, 4'd1, C_DEC);
    step(1'b0, SW, 1'b0, MR_LOW, 4'd2, C_MADR);
    step(1'b0, SW, 1'b0, MR_LOW, 4'd5, C_MWR);
    // R-type
    step(1'b0, RT, 1'b1, 1'b1, 4'd0, C_FETCH);
    step(1'b0, RT, 1'b1, 1'b1, 4'd1, C_DEC);
    step(1'b0, RT, 1'b1, 1'b1, 4'd6, C_EXEC);
    step(1'b0, RT, 1'b1, 1'b1, 4'd7, C_AWB);
    // beq taken then not taken
    step(1'b0, BEQ, 1'b1, 1'b1, 4'd0, C_FETCH);
    step(1'b0, BEQ, 1'b1, 1'b1, 4'd1, C_DEC);
    step(1'b0, BEQ, 1'b1, 1'b1, 4'd8, C_BR1);
    step(1'b0, BEQ, 1'b0, 1'b1, 4'd0, C_FETCH);
    step(1'b0, BEQ, 1'b0, 1'b1, 4'd1, C_DEC);
    step(1'b0, BEQ, 1'b0, 1'b1, 4'd8, C_BR0);
    // jump and addi
    step(1'b0, JMP, 1'b0, 1'b1, 4'd0, C_FETCH);
    step(1'b0, JMP, 1'b0, 1'b1, 4'd1, C_DEC);
    step(1'b0, JMP, 1'b0, 1'b1, 4'd9, C_JMP);
    step(1'b0, ADDI, 1'b0, 1'b1, 4'd0, C_FETCH);
    step(1'b0, ADDI, 1'b0, 1'b1, 4'd1, C_DEC);
    step(1'b0, ADDI, 1'b0, 1'b1, 4'd10, C_MADR);
    step(1'b0, ADDI, 1'b0, 1'b1, 4'd11, C_IWB);
    // illegal opcode: one-cycle pulse, straight back to FETCH
    step(1'b0, BAD, 1'b0, 1'b1, 4'd0, C_FETCH);
    step(1'b0, BAD, 1'b0, 1'b1, 4'd1, C_ILL);
    step(1'b0, LW, 1'b0, 1'b1, 4'd0, C_FETCH);
    // lw interrupted by reset in MEMWB
    step(1'b0, LW, 1'b0, 1'b1, 4'd1, C_DEC);
    step(1'b0, LW, 1'b0, 1'b1, 4'd2, C_MADR);
    step(1'b0, LW, 1'b0, 1'b1, 4'd3, C_MRD);
    step(1'b1, LW, 1'b0, 1'b1, 4'd4, C_ZERO);
    step(1'b0, LW, 1'b0, 1'b1, 4'd0, C_FETCH);
`ifdef MC_MEM_WAIT_EN
    // fetch stalled four cycles; PC and IR load only when memory is ready
    step(1'b0, SW, 1'b0, 1'b1, 4'd1, C_DEC);
    step(1'b0, SW, 1'b0, 1'b1, 4'd2, C_MADR);
    step(1'b0, SW, 1'b0, 1'b0, 4'd5, C_MWR);
    step(1'b0, SW, 1'b0, 1'b1, 4'd5, C_MWR);
    repeat (4) step(1'b0, RT, 1'b0, 1'b0, 4'd0, C_FWAIT);
    step(1'b0, RT, 1'b0, 1'b1, 4'd0, C_FETCH);
    step(1'b0, RT, 1'b0, 1'b1, 4'd1, C_DEC);
`else
    // mem_ready low is ignored without the wait option
    step(1'b0, RT, 1'b0, 1'b0, 4'd1, C_DEC);
    step(1'b0, RT, 1'b0, 1'b0, 4'd6, C_EXEC);
`endif
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths and opcode encodings are fixed by this document.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 op  input  6  instruction opcode field Instruction[31:26], valid from DECODE onward.
REQ-005 zf  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access complete, used only with MC_MEM_WAIT_EN.
REQ-007 pc_en  output  1  PC load enable, equal to pc_write OR (pc_write_cond AND zf).
REQ-008 i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-009 alu_src_b  output  2  selects 00 regB, 01 constant 4, 10 sign-extended imm, 11 shifted imm.
REQ-010 alu_op  output  3  000 add, 001 sub, 010 funct-decoded (R-type).
REQ-011 pc_source  output  2  selects 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 state  output  4  current state encoding, for debug.
REQ-013 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 The FSM states SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-015 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=000, pc_source=00, pc_write=1; next state DECODE.
REQ-016 DECODE: alu_src_b=11, alu_op=000. Next state by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, otherwise FETCH with illegal_op=1 for that cycle.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state MEMRD for op 100011, MEMWR for op 101011.
REQ-018 MEMRD: mem_read=1, i_or_d=1; next MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-019 MEMWR: mem_write=1, i_or_d=1; next FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; next ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_write_cond=1; next FETCH.
REQ-022 JUMP: pc_source=10, pc_write=1; next FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=000; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-024 Every control signal not listed for a state SHALL be 0 in that state.
REQ-025 Controls SHALL be Moore outputs decoded from the state register, except that pc_en, ir_write and illegal_op may also be qualified by zf, mem_ready or op as specified here.
REQ-026 Instruction latency SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 (no wait states).

Reset
REQ-027 While reset=1 at a rising edge, state SHALL become FETCH (0) and illegal_op SHALL be 0.
REQ-028 While reset is high, all control outputs, including pc_en, SHALL be forced to 0.
REQ-029 A reset asserted in any state, including a memory wait, SHALL abandon the instruction without any further reg_write, mem_write or pc_en pulse.
REQ-030 FETCH outputs SHALL appear in the first cycle after reset is released.

Configuration
REQ-031 Macro MC_MEM_WAIT_EN defined: FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0, with all other outputs held. In FETCH, ir_write and pc_write SHALL assert only in the cycle mem_ready=1, so PC advances exactly once per fetch.
REQ-032 MC_MEM_WAIT_EN undefined: mem_ready SHALL be ignored and each memory state SHALL last exactly one cycle.

Verification
REQ-033 Reset held 3 cycles, then released -> all controls 0 during reset; state=0, mem_read=1, pc_en=1 in the first cycle after release.
REQ-034 Sequence lw (100011) then sw (101011) -> state trace 0,1,2,3,4,0,1,2,5,0; reg_write=1 only in state 4, mem_write=1 only in state 5.
REQ-035 beq (000100) with zf=1, then with zf=0 -> pc_en=1 in state 8 for the first; pc_en=0 in state 8 for the second.
REQ-036 op=111111 in DECODE -> illegal_op=1 for exactly one cycle, then state=0 with no reg_write or mem_write.
REQ-037 MC_MEM_WAIT_EN, mem_ready=0 for 4 cycles in FETCH then 1 -> state stays 0 for 5 cycles; pc_en and ir_write are each 1 only in the fifth cycle.
REQ-038 reset asserted in state 4 (MEMWB) -> reg_write=0 in that cycle; state=0 on the next edge.
